// File: rtl/cmp_result_monitor.sv
// cmp_result_monitor: classifies comparator flag triples per handshake
// and reports windowed class counts plus the longest equal run.
module cmp_result_monitor #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_grth,
  input  logic             in_lsth,
  input  logic             in_eq,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_gt,
  output logic [CNT_W-1:0] rpt_lt,
  output logic [CNT_W-1:0] rpt_eq,
  output logic [CNT_W-1:0] rpt_err,
  output logic [CNT_W-1:0] rpt_max_eq_run
);

  localparam int SW = $clog2(WINDOW + 1);
  localparam logic [SW-1:0] LAST = SW'(WINDOW - 1);

  localparam logic [0:0] ACCUM  = 1'b0;
  localparam logic [0:0] REPORT = 1'b1;

  logic [0:0] state;

  logic [CNT_W-1:0] gt_q, lt_q, eq_q, err_q;
  logic [CNT_W-1:0] run_q, max_q;
  logic [SW-1:0]    cnt_q;

  logic [CNT_W-1:0] gt_n, lt_n, eq_n, err_n;
  logic [CNT_W-1:0] run_n, max_n;

  logic accept;
  logic last;
  logic c_gt, c_lt, c_eq, c_err;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_ready  = (state == ACCUM);
  assign rpt_valid = (state == REPORT);
  assign accept    = in_valid & in_ready;
  assign last      = accept & (cnt_q == LAST);

  // one-hot check of the flag triple picks exactly one class
  always_comb begin
    c_gt  = 1'b0;
    c_lt  = 1'b0;
    c_eq  = 1'b0;
    c_err = 1'b0;
    case ({in_grth, in_lsth, in_eq})
      3'b100:  c_gt  = 1'b1;
      3'b010:  c_lt  = 1'b1;
      3'b001:  c_eq  = 1'b1;
      default: c_err = 1'b1;
    endcase
  end

  // live counter and run values including the sample being accepted
  always_comb begin
    gt_n  = gt_q;
    lt_n  = lt_q;
    eq_n  = eq_q;
    err_n = err_q;
    run_n = run_q;
    max_n = max_q;
    if (accept) begin
      unique case (1'b1)
        c_gt:  gt_n  = sat_inc(gt_q);
        c_lt:  lt_n  = sat_inc(lt_q);
        c_eq:  eq_n  = sat_inc(eq_q);
        c_err: err_n = sat_inc(err_q);
      endcase
      run_n = c_eq ? sat_inc(run_q) : '0;
      if (run_n > max_q) max_n = run_n;
    end
  end

  // state and live window accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      gt_q  <= '0;
      lt_q  <= '0;
      eq_q  <= '0;
      err_q <= '0;
      run_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      state <= ACCUM;
      gt_q  <= '0;
      lt_q  <= '0;
      eq_q  <= '0;
      err_q <= '0;
      run_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else if (last) begin
      state <= REPORT;
      gt_q  <= '0;
      lt_q  <= '0;
      eq_q  <= '0;
      err_q <= '0;
      run_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      gt_q  <= gt_n;
      lt_q  <= lt_n;
      eq_q  <= eq_n;
      err_q <= err_n;
      run_q <= run_n;
      max_q <= max_n;
      cnt_q <= cnt_q + 1'b1;
    end else if (state == REPORT && rpt_ready) begin
      state <= ACCUM;
    end
  end

  // report snapshot, loaded only at window end and held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_gt         <= '0;
      rpt_lt         <= '0;
      rpt_eq         <= '0;
      rpt_err        <= '0;
      rpt_max_eq_run <= '0;
    end else if (!clr && last) begin
      rpt_gt         <= gt_n;
      rpt_lt         <= lt_n;
      rpt_eq         <= eq_n;
      rpt_err        <= err_n;
      rpt_max_eq_run <= max_n;
    end
  end

endmodule

// File: tb/tb_cmp_result_monitor.sv
// tb_cmp_result_monitor: directed vectors against a window-level model
// for WINDOW=4, plus a saturation run on a WINDOW=300 instance.
module tb_cmp_result_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic iv = 1'b0, ig = 1'b0, il = 1'b0, ie = 1'b0, rr = 1'b0;
  logic ir, rv;
  logic [7:0] o_gt, o_lt, o_eq, o_err, o_run;

  logic clr3 = 1'b0;
  logic iv3 = 1'b0, rr3 = 1'b0;
  logic ig3 = 1'b0, il3 = 1'b0, ie3 = 1'b1;
  logic ir3, rv3;
  logic [7:0] p_gt, p_lt, p_eq, p_err, p_run;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cmp_result_monitor #(.CNT_W(8), .WINDOW(4)) u4 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(iv), .in_ready(ir),
    .in_grth(ig), .in_lsth(il), .in_eq(ie),
    .rpt_valid(rv), .rpt_ready(rr),
    .rpt_gt(o_gt), .rpt_lt(o_lt), .rpt_eq(o_eq),
    .rpt_err(o_err), .rpt_max_eq_run(o_run)
  );

  cmp_result_monitor #(.CNT_W(8), .WINDOW(300)) u300 (
    .clk(clk), .rst(rst), .clr(clr3),
    .in_valid(iv3), .in_ready(ir3),
    .in_grth(ig3), .in_lsth(il3), .in_eq(ie3),
    .rpt_valid(rv3), .rpt_ready(rr3),
    .rpt_gt(p_gt), .rpt_lt(p_lt), .rpt_eq(p_eq),
    .rpt_err(p_err), .rpt_max_eq_run(p_run)
  );

  // model of the WINDOW=4 instance: samples kept as a class list
  localparam int MW = 4;
  int  win[$];
  bit  m_rep = 0;
  int  m_gt = 0, m_lt = 0, m_eq = 0, m_err = 0, m_run = 0;
  int  acc_cnt = 0;

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int cls(input logic g, l, e);
    if ({g, l, e} == 3'b100) return 0;
    if ({g, l, e} == 3'b010) return 1;
    if ({g, l, e} == 3'b001) return 2;
    return 3;
  endfunction

  // model state update on each clock edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      win.delete();
      m_rep = 0;
      m_gt = 0; m_lt = 0; m_eq = 0; m_err = 0; m_run = 0;
    end else if (clr) begin
      win.delete();
      m_rep = 0;
    end else if (!m_rep && iv) begin
      acc_cnt++;
      win.push_back(cls(ig, il, ie));
      if (win.size() == MW) begin
        int c[4];
        int run, best;
        c = '{0, 0, 0, 0};
        run = 0;
        best = 0;
        foreach (win[i]) begin
          c[win[i]]++;
          run = (win[i] == 2) ? run + 1 : 0;
          if (run > best) best = run;
        end
        m_gt = sat(c[0]); m_lt = sat(c[1]);
        m_eq = sat(c[2]); m_err = sat(c[3]);
        m_run = sat(best);
        win.delete();
        m_rep = 1;
      end
    end else if (m_rep && rr) begin
      m_rep = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // every-cycle compare of the WINDOW=4 instance against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(ir), 32'(!m_rep));
      chk("rpt_valid", 32'(rv), 32'(m_rep));
      chk("rpt_gt", 32'(o_gt), 32'(m_gt));
      chk("rpt_lt", 32'(o_lt), 32'(m_lt));
      chk("rpt_eq", 32'(o_eq), 32'(m_eq));
      chk("rpt_err", 32'(o_err), 32'(m_err));
      chk("rpt_run", 32'(o_run), 32'(m_run));
    end
  end

  task automatic feed(input logic g, l, e);
    int n0;
    n0 = acc_cnt;
    ig = g; il = l; ie = e; iv = 1'b1;
    for (int k = 0; k < 50 && acc_cnt == n0; k++) begin
      @(posedge clk);
      #1;
    end
    if (acc_cnt == n0) begin
      nvec++;
      nerr++;
      $display("FAIL feed_timeout: got 0 accepts want 1");
    end
  endtask

  task automatic take_report();
    rr = 1'b1;
    @(posedge clk);
    #1;
    rr = 1'b0;
  endtask

  task automatic lit(input string nm, input int g, l, e, x, r);
    chk({nm, "_gt"}, 32'(o_gt), 32'(g));
    chk({nm, "_lt"}, 32'(o_lt), 32'(l));
    chk({nm, "_eq"}, 32'(o_eq), 32'(e));
    chk({nm, "_err"}, 32'(o_err), 32'(x));
    chk({nm, "_run"}, 32'(o_run), 32'(r));
  endtask

  initial begin
    #3;
    chk("rst_ready", 32'(ir), 32'd1);
    chk("rst_valid", 32'(rv), 32'd0);
    lit("rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // test 1: one of each plus a run of two equals
    feed(1, 0, 0);
    feed(0, 1, 0);
    feed(0, 0, 1);
    feed(0, 0, 1);
    iv = 1'b0;
    @(negedge clk);
    chk("t1_valid", 32'(rv), 32'd1);
    chk("t1_ready", 32'(ir), 32'd0);
    lit("t1", 1, 1, 2, 0, 2);
    take_report();
    @(negedge clk);
    chk("t1_drop", 32'(rv), 32'd0);

    // test 2: none and multi-set flags are errors
    feed(0, 0, 0);
    feed(1, 1, 0);
    feed(0, 0, 1);
    feed(1, 1, 1);
    iv = 1'b0;
    @(negedge clk);
    lit("t2", 0, 0, 1, 3, 1);
    take_report();

    // test 3: stalled report with upstream holding a sample
    feed(0, 0, 1);
    feed(0, 0, 1);
    feed(1, 0, 0);
    feed(0, 0, 1);
    ig = 1'b0; il = 1'b1; ie = 1'b0; iv = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_stall_ready", 32'(ir), 32'd0);
      lit("t3_stall", 1, 0, 3, 0, 2);
    end
    @(posedge clk);
    #1;
    take_report();
    chk("t3_drop", 32'(rv), 32'd0);
    feed(0, 1, 0);
    feed(0, 0, 1);
    feed(0, 0, 1);
    feed(1, 1, 1);
    iv = 1'b0;
    @(negedge clk);
    lit("t3b", 0, 1, 2, 1, 2);
    take_report();

    // test 4: saturation on the WINDOW=300 instance
    iv3 = 1'b1;
    for (int k = 0; k < 299; k++) begin
      @(posedge clk);
    end
    #1;
    chk("t4_early_valid", 32'(rv3), 32'd0);
    @(posedge clk);
    #1;
    iv3 = 1'b0;
    @(negedge clk);
    chk("t4_valid", 32'(rv3), 32'd1);
    chk("t4_ready", 32'(ir3), 32'd0);
    chk("t4_gt", 32'(p_gt), 32'd0);
    chk("t4_lt", 32'(p_lt), 32'd0);
    chk("t4_eq", 32'(p_eq), 32'd255);
    chk("t4_err", 32'(p_err), 32'd0);
    chk("t4_run", 32'(p_run), 32'd255);
    rr3 = 1'b1;
    @(posedge clk);
    #1;
    rr3 = 1'b0;
    @(negedge clk);
    chk("t4_drop", 32'(rv3), 32'd0);

    // test 5: clear discards partial window and same-cycle sample
    feed(1, 0, 0);
    feed(1, 0, 0);
    ig = 1'b0; il = 1'b0; ie = 1'b1; iv = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    for (int k = 0; k < 4; k++) feed(1, 0, 0);
    iv = 1'b0;
    @(negedge clk);
    chk("t5_valid", 32'(rv), 32'd1);
    lit("t5", 4, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(rv), 32'd0);
    chk("t5_rst_ready", 32'(ir), 32'd1);
    lit("t5_rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    feed(0, 1, 0);
    iv = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
